// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer state encodings, the
// hard-wired zero register and the default memory-timeout cause code.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN          = 3'd0,
        ST_MEM_WAIT     = 3'd1,
        ST_EXC_FLUSH    = 3'd2,
        ST_EXC_REDIRECT = 3'd3
    } state_t;

    localparam logic [3:0] REG_ZERO         = 4'h0;
    localparam logic [3:0] DEF_TIMEOUT_CODE = 4'hF;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the EX-stage load and the
// ID-stage source operands; shared with the forwarding unit.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] idRs1,
    input  logic [3:0] idRs2,
    input  logic       idUsesRs2,
    input  logic [3:0] exRd,
    input  logic       exIsLoad,
    input  logic       exRegWrite,
    output logic       loadUse
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (exRd == idRs1);
    assign rs2_hit = idUsesRs2 & (exRd == idRs2);

    // Writes to the zero register are discarded, so they never create a hazard.
    assign loadUse = exIsLoad & exRegWrite & (exRd != REG_ZERO) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/stall_sequencer.sv
// Prioritised stall / freeze / flush sequencer for the 5-stage pipeline:
// exception flush > memory-wait freeze > load-use interlock.
module stall_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int         MEM_TIMEOUT  = 15,
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [3:0] TIMEOUT_CODE = DEF_TIMEOUT_CODE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] idRs1,
    input  logic [3:0] idRs2,
    input  logic       idUsesRs2,
    input  logic [3:0] exRd,
    input  logic       exIsLoad,
    input  logic       exRegWrite,
    input  logic       memReq,
    input  logic       memReady,
    input  logic       excValid,
    input  logic [3:0] excCode,
    output logic       pcWrite,
    output logic       ifidWrite,
    output logic       idexBubble,
    output logic       pipeHold,
    output logic       flushIfId,
    output logic       flushIdEx,
    output logic       flushExMem,
    output logic       pcSelVector,
    output logic [3:0] excCause,
    output logic       memTimeout,
    output logic [2:0] state
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t     cur_st;
    logic [7:0] wait_cnt;
    logic [2:0] flush_cnt;
    logic [2:0] flush_nxt;
    logic       load_use;
    logic       timeout_hit;

    load_use_detect u_load_use (
        .idRs1      (idRs1),
        .idRs2      (idRs2),
        .idUsesRs2  (idUsesRs2),
        .exRd       (exRd),
        .exIsLoad   (exIsLoad),
        .exRegWrite (exRegWrite),
        .loadUse    (load_use)
    );

    assign flush_nxt   = flush_cnt + 3'd1;
    assign timeout_hit = (wait_cnt == WAIT_LIMIT);
    assign state       = cur_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st    <= ST_RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
            excCause  <= '0;
        end else begin
            case (cur_st)
                ST_RUN: begin
                    if (excValid) begin
                        excCause  <= excCode;
                        flush_cnt <= '0;
                        cur_st    <= ST_EXC_FLUSH;
                    end else if (memReq & ~memReady) begin
                        wait_cnt <= 8'd1;
                        cur_st   <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (excValid) begin
                        excCause  <= excCode;
                        flush_cnt <= '0;
                        cur_st    <= ST_EXC_FLUSH;
                    end else if (memReady) begin
                        wait_cnt <= '0;
                        cur_st   <= ST_RUN;
                    end else if (timeout_hit) begin
                        excCause  <= TIMEOUT_CODE;
                        flush_cnt <= '0;
                        cur_st    <= ST_EXC_FLUSH;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                // The entry cycle already flushed, so this state needs FLUSH_CYCLES-1 cycles.
                ST_EXC_FLUSH: begin
                    flush_cnt <= flush_nxt;
                    if (flush_nxt >= FLUSH_LAST) begin
                        cur_st <= ST_EXC_REDIRECT;
                    end
                end
                ST_EXC_REDIRECT: begin
                    cur_st <= ST_RUN;
                end
                default: begin
                    cur_st <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexBubble  = 1'b0;
        pipeHold    = 1'b0;
        flushIfId   = 1'b0;
        flushIdEx   = 1'b0;
        flushExMem  = 1'b0;
        pcSelVector = 1'b0;
        memTimeout  = 1'b0;
        if (!rst_n) begin
            // Keep the pipeline frozen for as long as reset is held.
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            pipeHold  = 1'b1;
        end else begin
            case (cur_st)
                ST_RUN: begin
                    if (excValid) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        flushIfId  = 1'b1;
                        flushIdEx  = 1'b1;
                        flushExMem = 1'b1;
                    end else if (memReq & ~memReady) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        pipeHold  = 1'b1;
                    end else if (load_use) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexBubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (excValid) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        pipeHold   = 1'b1;
                        flushIfId  = 1'b1;
                        flushIdEx  = 1'b1;
                        flushExMem = 1'b1;
                    end else if (!memReady) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        pipeHold   = 1'b1;
                        memTimeout = timeout_hit;
                    end
                end
                ST_EXC_FLUSH: begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    flushIfId  = 1'b1;
                    flushIdEx  = 1'b1;
                    flushExMem = 1'b1;
                end
                ST_EXC_REDIRECT: begin
                    pcSelVector = 1'b1;
                    flushIfId   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stall_sequencer.sv
// Directed bench for stall_sequencer: load-use, memory freeze, timeout,
// exception flush/redirect, priority and asynchronous reset.
module tb_stall_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] idRs1, idRs2, exRd, excCode;
    logic       idUsesRs2, exIsLoad, exRegWrite, memReq, memReady, excValid;

    logic       pcWrite, ifidWrite, idexBubble, pipeHold;
    logic       flushIfId, flushIdEx, flushExMem, pcSelVector, memTimeout;
    logic [3:0] excCause;
    logic [2:0] state;

    logic       w_pcWrite, w_ifidWrite, w_idexBubble, w_pipeHold;
    logic       w_flushIfId, w_flushIdEx, w_flushExMem, w_pcSelVector, w_memTimeout;
    logic [3:0] w_excCause;
    logic [2:0] w_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stall_sequencer #(.MEM_TIMEOUT(3), .FLUSH_CYCLES(2), .TIMEOUT_CODE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs2(idUsesRs2),
        .exRd(exRd), .exIsLoad(exIsLoad), .exRegWrite(exRegWrite), .memReq(memReq),
        .memReady(memReady), .excValid(excValid), .excCode(excCode),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexBubble(idexBubble),
        .pipeHold(pipeHold), .flushIfId(flushIfId), .flushIdEx(flushIdEx),
        .flushExMem(flushExMem), .pcSelVector(pcSelVector), .excCause(excCause),
        .memTimeout(memTimeout), .state(state)
    );

    // Default-timeout instance for the long memory-wait scenario.
    stall_sequencer dut_w (
        .clk(clk), .rst_n(rst_n), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs2(idUsesRs2),
        .exRd(exRd), .exIsLoad(exIsLoad), .exRegWrite(exRegWrite), .memReq(memReq),
        .memReady(memReady), .excValid(excValid), .excCode(excCode),
        .pcWrite(w_pcWrite), .ifidWrite(w_ifidWrite), .idexBubble(w_idexBubble),
        .pipeHold(w_pipeHold), .flushIfId(w_flushIfId), .flushIdEx(w_flushIdEx),
        .flushExMem(w_flushExMem), .pcSelVector(w_pcSelVector), .excCause(w_excCause),
        .memTimeout(w_memTimeout), .state(w_state)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        idRs1 = 4'd0; idRs2 = 4'd0; idUsesRs2 = 1'b0; exRd = 4'd0;
        exIsLoad = 1'b0; exRegWrite = 1'b0; memReq = 1'b0; memReady = 1'b0;
        excValid = 1'b0; excCode = 4'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        rst_n = 1'b0;
        #12;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_pipeHold", 8'(pipeHold), 8'd1);
        chk("rst_pcWrite", 8'(pcWrite), 8'd0);
        chk("rst_excCause", 8'(excCause), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_pcWrite", 8'(pcWrite), 8'd1);
        chk("rel_pipeHold", 8'(pipeHold), 8'd0);

        // load-use on rs1
        step();
        exIsLoad = 1'b1; exRegWrite = 1'b1; exRd = 4'd3; idRs1 = 4'd3;
        @(negedge clk);
        chk("lu_bubble", 8'(idexBubble), 8'd1);
        chk("lu_pcWrite", 8'(pcWrite), 8'd0);
        chk("lu_ifidWrite", 8'(ifidWrite), 8'd0);
        step();
        clr();
        @(negedge clk);
        chk("lu_after_bubble", 8'(idexBubble), 8'd0);
        chk("lu_after_pcWrite", 8'(pcWrite), 8'd1);
        step();
        exIsLoad = 1'b1; exRegWrite = 1'b1; exRd = 4'd0; idRs1 = 4'd0;
        @(negedge clk);
        chk("lu_r0_bubble", 8'(idexBubble), 8'd0);
        chk("lu_r0_pcWrite", 8'(pcWrite), 8'd1);
        step();
        exRd = 4'd6; idRs1 = 4'd1; idRs2 = 4'd6; idUsesRs2 = 1'b1;
        @(negedge clk);
        chk("lu_rs2_bubble", 8'(idexBubble), 8'd1);
        step();
        idUsesRs2 = 1'b0;
        @(negedge clk);
        chk("lu_rs2_unused", 8'(idexBubble), 8'd0);

        // memory timeout, MEM_TIMEOUT=3
        step();
        clr();
        memReq = 1'b1;
        @(negedge clk);
        chk("to_enter_hold", 8'(pipeHold), 8'd1);
        chk("to_enter_state", 8'(state), 8'd0);
        step();
        @(negedge clk);
        chk("to_w1_state", 8'(state), 8'd1);
        chk("to_w1_pulse", 8'(memTimeout), 8'd0);
        step();
        @(negedge clk);
        chk("to_w2_pulse", 8'(memTimeout), 8'd0);
        step();
        @(negedge clk);
        chk("to_w3_pulse", 8'(memTimeout), 8'd1);
        chk("to_w3_hold", 8'(pipeHold), 8'd1);
        step();
        memReq = 1'b0;
        @(negedge clk);
        chk("to_flush_state", 8'(state), 8'd2);
        chk("to_flush_pulse", 8'(memTimeout), 8'd0);
        chk("to_excCause", 8'(excCause), 8'hF);
        chk("to_flushIdEx", 8'(flushIdEx), 8'd1);
        step();
        @(negedge clk);
        chk("to_redir_state", 8'(state), 8'd3);
        chk("to_redir_pcSel", 8'(pcSelVector), 8'd1);
        chk("to_redir_pcWrite", 8'(pcWrite), 8'd1);
        chk("to_redir_flushIfId", 8'(flushIfId), 8'd1);
        chk("to_redir_flushExMem", 8'(flushExMem), 8'd0);
        step();
        @(negedge clk);
        chk("to_run_state", 8'(state), 8'd0);
        chk("to_run_pcSel", 8'(pcSelVector), 8'd0);

        // exception while in MEM_WAIT
        step();
        memReq = 1'b1;
        step();
        excValid = 1'b1; excCode = 4'd5;
        @(negedge clk);
        chk("mx_state", 8'(state), 8'd1);
        chk("mx_flushExMem", 8'(flushExMem), 8'd1);
        chk("mx_flushIfId", 8'(flushIfId), 8'd1);
        step();
        memReq = 1'b0; excValid = 1'b1; excCode = 4'd9;
        @(negedge clk);
        chk("mx_flush_state", 8'(state), 8'd2);
        chk("mx_flush_cause", 8'(excCause), 8'd5);
        step();
        clr();
        @(negedge clk);
        chk("mx_redir_state", 8'(state), 8'd3);
        chk("mx_redir_cause", 8'(excCause), 8'd5);
        step();
        @(negedge clk);
        chk("mx_run_state", 8'(state), 8'd0);

        // priority: exception beats memory wait and load-use
        step();
        excValid = 1'b1; excCode = 4'd7; memReq = 1'b1;
        exIsLoad = 1'b1; exRegWrite = 1'b1; exRd = 4'd3; idRs1 = 4'd3;
        @(negedge clk);
        chk("pr_bubble", 8'(idexBubble), 8'd0);
        chk("pr_flushIdEx", 8'(flushIdEx), 8'd1);
        chk("pr_pipeHold", 8'(pipeHold), 8'd0);
        step();
        clr();
        @(negedge clk);
        chk("pr_flush_state", 8'(state), 8'd2);
        chk("pr_cause", 8'(excCause), 8'd7);

        // asynchronous reset during EXC_FLUSH, no clock edge in between
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_state", 8'(state), 8'd0);
        chk("ar_cause", 8'(excCause), 8'd0);
        chk("ar_pipeHold", 8'(pipeHold), 8'd1);
        chk("ar_flushIdEx", 8'(flushIdEx), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // memory freeze: ready low for 4 cycles, then high (default timeout)
        step();
        memReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mw_hold_%0d", i), 8'(w_pipeHold), 8'd1);
            chk($sformatf("mw_nopulse_%0d", i), 8'(w_memTimeout), 8'd0);
            step();
        end
        memReady = 1'b1;
        @(negedge clk);
        chk("mw_ready_state", 8'(w_state), 8'd1);
        chk("mw_ready_hold", 8'(w_pipeHold), 8'd0);
        chk("mw_ready_pcWrite", 8'(w_pcWrite), 8'd1);
        step();
        clr();
        @(negedge clk);
        chk("mw_run_state", 8'(w_state), 8'd0);
        chk("mw_run_hold", 8'(w_pipeHold), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
